// File: rtl/conv_window_ctrl.sv
// Window sequencer for a 5x5 convolution PE: raster window requests, a 2-stage result tag
// pipeline and a credit-gated result FIFO. Optional stall counter under CONV_CTRL_PERF_EN.
module conv_window_ctrl #(
  parameter int OUT_W      = 24,
  parameter int OUT_H      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        relu_cfg,
  input  logic        quan_cfg,
  output logic        busy,
  output logic        done,
  output logic        win_req,
  output logic [4:0]  win_row,
  output logic [4:0]  win_col,
  input  logic        win_ack,
  output logic        pe_relu_en,
  output logic        pe_quan_en,
  input  logic [31:0] pe_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_row,
  output logic [4:0]  res_col,
  input  logic        res_ready
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      row_q, row_d, col_q, col_d;
  logic            relu_q, quan_q;
  logic            v1_q, v2_q;
  logic [4:0]      r1_q, c1_q, r2_q, c2_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [41:0]     mem [FIFO_DEPTH];
  logic [41:0]     head;
  logic [5:0]      used;
  logic            hs, accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight PE results and queued ones, so the FIFO cannot overflow.
  assign used      = 6'(v1_q) + 6'(v2_q) + 6'(cnt_q);
  assign win_req   = (state_q == RUN) && (used < 6'(FIFO_DEPTH));
  assign hs        = win_req && win_ack;
  assign accept    = start && (state_q == IDLE);
  assign push      = v2_q;
  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid && res_ready;
  assign busy      = (state_q != IDLE);
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign pe_relu_en = relu_q;
  assign pe_quan_en = quan_q;

  assign head     = mem[rd_ptr_q];
  assign res_data = res_valid ? head[41:10] : '0;
  assign res_row  = res_valid ? head[9:5]   : '0;
  assign res_col  = res_valid ? head[4:0]   : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        row_d   = '0;
        col_d   = '0;
      end
      RUN: if (hs) begin
        if (col_q == 5'(OUT_W - 1)) begin
          col_d = '0;
          if (row_q == 5'(OUT_H - 1)) begin
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      // Leave as soon as the last result is popped so done follows it directly.
      DRAIN: if (!v1_q && !v2_q && (cnt_d == '0)) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      relu_q   <= 1'b0;
      quan_q   <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      r1_q     <= '0;
      c1_q     <= '0;
      r2_q     <= '0;
      c2_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (accept) begin
        relu_q <= relu_cfg;
        quan_q <= quan_cfg;
      end
      v1_q <= hs;
      r1_q <= row_q;
      c1_q <= col_q;
      v2_q <= v1_q;
      r2_q <= r1_q;
      c2_q <= c1_q;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {pe_out, r2_q, c2_q};
  end

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] stall_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !win_req && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: drives a 24x24, a 2x2 and a 1x1 instance from shared stimulus, each with
// its own 2-cycle PE model and a raster-order scoreboard on the result port.
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, relu_cfg = 1'b0, quan_cfg = 1'b0;
  logic win_ack = 1'b0, res_ready = 1'b0;

  logic        busy_w [3], done_w [3], wreq_w [3], rv_w [3], relu_w [3], quan_w [3];
  logic [4:0]  wrow_w [3], wcol_w [3], rrow_w [3], rcol_w [3];
  logic [31:0] rdata_w [3], pe_w [3], p1 [3];
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] stall_w [3];
`endif

  int total = 0, bad = 0;
  int exp_r [3], exp_c [3], npop [3], ndone [3];
  int dim_of [3] = '{24, 2, 1};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DIM = (gi == 0) ? 24 : ((gi == 1) ? 2 : 1);
    conv_window_ctrl #(.OUT_W(DIM), .OUT_H(DIM), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .relu_cfg(relu_cfg), .quan_cfg(quan_cfg),
      .busy(busy_w[gi]), .done(done_w[gi]), .win_req(wreq_w[gi]),
      .win_row(wrow_w[gi]), .win_col(wcol_w[gi]), .win_ack(win_ack),
      .pe_relu_en(relu_w[gi]), .pe_quan_en(quan_w[gi]), .pe_out(pe_w[gi]),
      .res_valid(rv_w[gi]), .res_data(rdata_w[gi]), .res_row(rrow_w[gi]),
      .res_col(rcol_w[gi]), .res_ready(res_ready)
`ifdef CONV_CTRL_PERF_EN
      , .stall_cnt(stall_w[gi])
`endif
    );
  end

  function automatic logic [31:0] f(input int k, input int r, input int c);
    return 32'hA000_0000 | (32'(k) << 16) | (32'(r) << 8) | 32'(c);
  endfunction

  // PE model: operands accepted at a handshake edge, result valid after the next edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      p1[k]   <= (wreq_w[k] && win_ack) ? f(k, int'(wrow_w[k]), int'(wcol_w[k])) : 32'hDEAD_BEEF;
      pe_w[k] <= p1[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 3; k++) begin
      exp_r[k] = 0; exp_c[k] = 0; npop[k] = 0; ndone[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (rv_w[k] && res_ready) begin
          check($sformatf("pop%0d_row", k),  32'(rrow_w[k]), 32'(exp_r[k]));
          check($sformatf("pop%0d_col", k),  32'(rcol_w[k]), 32'(exp_c[k]));
          check($sformatf("pop%0d_data", k), rdata_w[k], f(k, exp_r[k], exp_c[k]));
          $display("pop inst=%0d row=%0d col=%0d data=%h", k, rrow_w[k], rcol_w[k], rdata_w[k]);
          npop[k]++;
          exp_c[k]++;
          if (exp_c[k] == dim_of[k]) begin
            exp_c[k] = 0;
            exp_r[k]++;
          end
        end
        if (done_w[k]) ndone[k]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic relu, input logic quan);
    start = 1'b1; relu_cfg = relu; quan_cfg = quan;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy_w[k]) break;
    end
    check($sformatf("timeout_busy%0d", k), 32'(busy_w[k]), 32'd0);
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_busy"},  32'(busy_w[k]), 0);
    check({tag, "_done"},  32'(done_w[k]), 0);
    check({tag, "_wreq"},  32'(wreq_w[k]), 0);
    check({tag, "_rv"},    32'(rv_w[k]), 0);
    check({tag, "_relu"},  32'(relu_w[k]), 0);
    check({tag, "_quan"},  32'(quan_w[k]), 0);
    check({tag, "_wrow"},  32'(wrow_w[k]), 0);
    check({tag, "_wcol"},  32'(wcol_w[k]), 0);
    check({tag, "_rdata"}, rdata_w[k], 0);
    check({tag, "_rrow"},  32'(rrow_w[k]), 0);
    check({tag, "_rcol"},  32'(rcol_w[k]), 0);
  endtask

  typedef struct packed {
    logic       win_req, busy, done, res_valid;
    logic [4:0] win_row, win_col, res_row, res_col;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int hs;
    // 2x2 pass, ack and ready high; index = cycles after the edge that accepts start.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 5'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 5'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 5'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 5'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0};
    clear_sb();

    // Reset state on every instance.
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_zero(k, $sformatf("rst%0d", k));
    step();
    rst = 1'b0;
    step();

    // Table-driven 2x2 pass; a second start with relu_cfg=0 arrives mid-pass.
    win_ack = 1'b1; res_ready = 1'b1;
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      vec_t act;
      @(negedge clk);
      act = '{wreq_w[1], busy_w[1], done_w[1], rv_w[1], wrow_w[1], wcol_w[1], rrow_w[1], rcol_w[1]};
      check($sformatf("tbl_cycle%0d", i), 32'(act), 32'(tbl[i]));
      $display("cycle %0d: req=%0b busy=%0b done=%0b rv=%0b win=(%0d,%0d) res=(%0d,%0d)",
               i, act.win_req, act.busy, act.done, act.res_valid, act.win_row, act.win_col,
               act.res_row, act.res_col);
      step();
      if (i == 1) begin
        start = 1'b1; relu_cfg = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    wait_idle(0, 1000);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("passA_npop%0d", k),  32'(npop[k]), 32'(dim_of[k] * dim_of[k]));
      check($sformatf("passA_ndone%0d", k), 32'(ndone[k]), 32'd1);
      check($sformatf("passA_relu%0d", k),  32'(relu_w[k]), 32'd1);
      check($sformatf("passA_quan%0d", k),  32'(quan_w[k]), 32'd0);
    end

    // Consumer stalls: credits cap handshakes at FIFO_DEPTH, then ack-hold stability.
    clear_sb();
    res_ready = 1'b0;
    pulse_start(1'b0, 1'b1);
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wreq_w[0] && win_ack) hs++;
      step();
    end
    check("stall_hs", 32'(hs), 32'd4);
    check("stall_wreq", 32'(wreq_w[0]), 32'd0);
    check("stall_rv", 32'(rv_w[0]), 32'd1);
    check("stall_npop", 32'(npop[0]), 32'd0);
    check("stall_relu", 32'(relu_w[0]), 32'd0);
    check("stall_quan", 32'(quan_w[0]), 32'd1);
`ifdef CONV_CTRL_PERF_EN
    check("stall_cnt_nonzero", 32'(stall_w[0] != 0), 32'd1);
`endif
    res_ready = 1'b1; win_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_row", 32'(wrow_w[0]), 32'd0);
      check("hold_col", 32'(wcol_w[0]), 32'd4);
      if (i == 4) check("hold_wreq", 32'(wreq_w[0]), 32'd1);
      step();
    end
    win_ack = 1'b1;
    step();
    win_ack = 1'b0;
    @(negedge clk);
    check("adv_row", 32'(wrow_w[0]), 32'd0);
    check("adv_col", 32'(wcol_w[0]), 32'd5);
    step();
    win_ack = 1'b1;
    wait_idle(0, 2000);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("passB_npop%0d", k),  32'(npop[k]), 32'(dim_of[k] * dim_of[k]));
      check($sformatf("passB_ndone%0d", k), 32'(ndone[k]), 32'd1);
    end

    // Asynchronous reset mid-pass with results in flight, then a clean pass.
    clear_sb();
    pulse_start(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    check("pre_rst_rv", 32'(rv_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_zero(0, "arst");
    step();
    step();
    rst = 1'b0;
    clear_sb();
    step();
    pulse_start(1'b0, 1'b0);
    wait_idle(0, 2000);
    check("passC_npop", 32'(npop[0]), 32'd576);
    check("passC_ndone", 32'(ndone[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
